imem_load_ctrl: RTL
===================

# imem_load_ctrl

Sequencer that owns the pipelined CPU's instruction-memory write port and its `cpu_en` enable. It accepts instruction words from a host over a valid/ready stream, writes them into instruction memory one per cycle, and holds the CPU halted while loading. On command it runs the CPU for a bounded or unbounded number of cycles, then halts it, drains the pipeline and reports completion. It sits between the host/test harness and `top_level`, replacing direct pokes of `w_enable`/`w_adrs`/`w_instruction`/`cpu_en`.

## Interface
- `ADDR_W`, 11: instruction-memory address width.
- `DATA_W`, 32: instruction width.
- `RUN_CNT_W`, 16: width of the run-cycle budget.
- `DRAIN_CYCLES`, 4: halted cycles spent in DRAIN before the CPU is reported done; must be ≥1.

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-high reset. Asserted = 1; the name is kept for codebase consistency only.
- `s_valid` in 1: host word valid.
- `s_ready` out 1: controller can accept a word.
- `s_addr` in ADDR_W: target instruction address.
- `s_data` in DATA_W: instruction word.
- `s_last` in 1: final word of a load burst.
- `run_req` in 1: start CPU (level, sampled in IDLE).
- `run_cycles` in RUN_CNT_W: run budget, sampled with `run_req`; 0 = unbounded.
- `halt_req` in 1: stop a running CPU.
- `cpu_en` out 1: CPU enable.
- `w_enable` out 1: imem write strobe.
- `w_adrs` out ADDR_W: imem write address.
- `w_instruction` out DATA_W: imem write data.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on DRAIN→IDLE.
- `words_loaded` out ADDR_W+1: words written in the current/last burst, saturating at 2^ADDR_W.

## Operation
- **States:** IDLE, LOAD, RUN, DRAIN. All outputs are registered.
- **`s_ready` per state:** 1 in IDLE and LOAD; 0 in RUN and DRAIN.
- **IDLE:**
  - Handshake (`s_valid & s_ready`): clear `words_loaded` to 1, issue a write, go to LOAD, or stay in IDLE if `s_last`.
  - Otherwise, `run_req` latches `run_cycles` into the run counter and goes to RUN.
- **LOAD:**
  - Each handshake issues a write and increments `words_loaded`.
  - A handshake with `s_last` returns to IDLE.
  - `run_req` is ignored in LOAD.
- **Write:** `w_enable` = 1 for exactly one cycle per accepted word, with `w_adrs = s_addr` and `w_instruction = s_data`. Back-to-back words give consecutive write cycles. `w_adrs`/`w_instruction` hold their last values when `w_enable` = 0.
- **RUN:**
  - `cpu_en` = 1.
  - If the budget is N ≠ 0, the counter decrements each cycle; on the Nth RUN cycle, go to DRAIN.
  - `halt_req` goes to DRAIN immediately.
- **DRAIN:**
  - `cpu_en` = 0; count DRAIN_CYCLES cycles, then go to IDLE with `done` = 1 for one cycle.
- **Simultaneous events:**
  - `s_valid` and `run_req` in IDLE: the load wins; `run_req` must be re-presented.
  - `halt_req` on the same cycle as budget expiry: a single DRAIN entry and a single `done`.
  - `halt_req` in IDLE/LOAD/DRAIN: ignored.
- **Address:** the controller does no address checking; `s_addr` wraps naturally within ADDR_W.

## Timing
- **Reset:** state IDLE, and `cpu_en`, `w_enable`, `w_adrs`, `w_instruction`, `busy`, `done`, `words_loaded` all 0. `s_ready` is 1 from the first cycle after reset deasserts.
- **Reset mid-run or mid-load:** `cpu_en`/`w_enable` drop at that edge; no `done`.
- **Write latency:** handshake at edge k gives `w_enable` high during cycle k..k+1 (one edge later).
- **Run start:** `run_req` sampled at edge k gives `cpu_en` high from edge k. With budget N, `cpu_en` is high for exactly N cycles.
- **Halt:** `halt_req` sampled at edge k gives `cpu_en` low from edge k.
- **`done`:** asserted DRAIN_CYCLES cycles after `cpu_en` falls.
- **Throughput:** one word per cycle; `s_ready` never deasserts within a burst.

## Configuration
- **`IMEM_LOAD_CHECKSUM_EN`**
- **Defined:**
  - Adds output `checksum` (DATA_W).
  - `checksum` is the running XOR of every `w_instruction` written in the current burst.
  - It is cleared by the first word of a burst and updates in the same cycle as `w_enable`.
  - Reset value is 0.
- **Undefined:** no `checksum` port and no checksum logic; all other behaviour is identical.

## Test plan
- **Reset:** assert `resetn` = 1 for 2 cycles → all outputs 0, `s_ready` = 1 after release.
- **Load burst:** words 0xE0000C07@1, 0xE0460007@2, 0xC0FFFC03@4 (`s_last`) back-to-back → three consecutive `w_enable` pulses with matching `w_adrs`/`w_instruction`, `words_loaded` = 3, state IDLE. With the macro defined, `checksum` = XOR of the three words.
- **Bounded run:** `run_req` with `run_cycles` = 17 → `cpu_en` high exactly 17 cycles; `done` pulses 4 cycles after `cpu_en` falls; `s_ready` = 0 throughout.
- **Unbounded run with halt:** `run_cycles` = 0, `halt_req` at cycle 30 → `cpu_en` falls at that edge, `done` once; a `halt_req` repeated in IDLE has no effect.
- **Simultaneous events:**
  - `s_valid` + `run_req` in IDLE → word written, no run.
  - `halt_req` on the final budget cycle → a single `done`.
- **Reset mid-run and saturation:** reset mid-run → `cpu_en` 0 next edge, no `done`. Separately, load 2049 words → `words_loaded` saturates at 2048 and `w_adrs` wraps to 0.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// Host-to-controller instruction word stream (valid/ready with burst-end marker).
interface imem_load_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, s_addr, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_addr, s_data, s_last, output s_ready);
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader and CPU run/halt sequencer for top_level.
// Optional feature macro IMEM_LOAD_CHECKSUM_EN adds a per-burst XOR checksum output.
module imem_load_ctrl #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RUN_CNT_W    = 16,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    imem_load_ctrl_if.slave      s,
    input  logic                 run_req,
    input  logic [RUN_CNT_W-1:0] run_cycles,
    input  logic                 halt_req,
    output logic                 cpu_en,
    output logic                 w_enable,
    output logic [ADDR_W-1:0]    w_adrs,
    output logic [DATA_W-1:0]    w_instruction,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      words_loaded
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]    checksum
`endif
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W:0]    WORDS_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [ADDR_W:0]      words_q, words_d;
    logic [ADDR_W-1:0]    w_adrs_q, w_adrs_d;
    logic [DATA_W-1:0]    w_instr_q, w_instr_d;
    logic                 w_en_q, w_en_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 s_ready_q, s_ready_d;
    logic                 hs;

    assign hs = s.s_valid & s_ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        drain_cnt_d = drain_cnt_q;
        words_d     = words_q;
        w_adrs_d    = w_adrs_q;
        w_instr_d   = w_instr_q;
        w_en_d      = 1'b0;
        cpu_en_d    = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    words_d   = (ADDR_W+1)'(1);
                    w_en_d    = 1'b1;
                    w_adrs_d  = s.s_addr;
                    w_instr_d = s.s_data;
                    if (!s.s_last) state_d = LOAD;
                end else if (run_req) begin
                    run_cnt_d = run_cycles;
                    cpu_en_d  = 1'b1;
                    state_d   = RUN;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (words_q != WORDS_MAX) words_d = words_q + (ADDR_W+1)'(1);
                    w_en_d    = 1'b1;
                    w_adrs_d  = s.s_addr;
                    w_instr_d = s.s_data;
                    if (s.s_last) state_d = IDLE;
                end
            end
            RUN: begin
                // A zero budget never reaches 1, so it runs until halted
                if (halt_req || run_cnt_q == RUN_CNT_W'(1)) begin
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = DRAIN;
                end else begin
                    cpu_en_d = 1'b1;
                    if (run_cnt_q != '0) run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            words_q     <= '0;
            w_adrs_q    <= '0;
            w_instr_q   <= '0;
            w_en_q      <= 1'b0;
            cpu_en_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            words_q     <= words_d;
            w_adrs_q    <= w_adrs_d;
            w_instr_q   <= w_instr_d;
            w_en_q      <= w_en_d;
            cpu_en_q    <= cpu_en_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            s_ready_q   <= s_ready_d;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    // First word of a burst (accepted in IDLE) restarts the running XOR
    always_comb begin
        chk_d = chk_q;
        if (hs) chk_d = (state_q == IDLE) ? s.s_data : (chk_q ^ s.s_data);
    end

    always_ff @(posedge clk) begin
        if (resetn) chk_q <= '0;
        else        chk_q <= chk_d;
    end

    assign checksum = chk_q;
`endif

    assign s.s_ready     = s_ready_q;
    assign cpu_en        = cpu_en_q;
    assign w_enable      = w_en_q;
    assign w_adrs        = w_adrs_q;
    assign w_instruction = w_instr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_loaded  = words_q;

endmodule
